branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter BHT_ENTRIES, default 32, number of 2-bit counters; power of two, 4..256.
REQ-002 Parameter IDX_W, default $clog2(BHT_ENTRIES), table index width.
REQ-003 i_clk  input  1  sole clock; all state on rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_lk_valid  input  1  lookup request this cycle.
REQ-006 i_lk_pc  input  DATA_SIZE  PC of instruction being fetched.
REQ-007 o_pred_valid  output  1  prediction valid; registered, one cycle after i_lk_valid.
REQ-008 o_pred_taken  output  1  predicted direction for the registered lookup.
REQ-009 i_upd_valid  input  1  resolved branch outcome present.
REQ-010 i_upd_pc  input  DATA_SIZE  PC of the resolved branch.
REQ-011 i_upd_taken  input  1  actual outcome, driven by the branch comparator result.
REQ-012 i_upd_pred  input  1  prediction originally issued for that branch.
REQ-013 o_mispredict  output  1  registered; pulses one cycle after an update whose i_upd_taken != i_upd_pred.
REQ-014 i_flush  input  1  single-cycle request to reinitialise the table.
REQ-015 o_busy  output  1  high while a flush sweep is in progress.
REQ-016 o_mispred_cnt  output  16  saturating count of mispredictions since reset.

Function
REQ-017 Index SHALL be pc[IDX_W+1:2]; pc[1:0] ignored.
REQ-018 Each entry SHALL be a 2-bit saturating counter: SNT=00, WNT=01, WT=10, ST=11; predict taken iff counter MSB = 1.
REQ-019 An update with taken SHALL increment the counter, saturating at ST; with not-taken, decrement, saturating at SNT.
REQ-020 Lookup latency SHALL be exactly one cycle; o_pred_valid SHALL equal i_lk_valid delayed one cycle, with no backpressure.
REQ-021 Same-cycle lookup and update to the same index SHALL bypass: the prediction reflects the post-update counter value.
REQ-022 Same-cycle lookup and update to different indices SHALL be independent.
REQ-023 o_mispredict SHALL be high for exactly one cycle per mispredicting update; it SHALL be 0 when i_upd_valid = 0.
REQ-024 o_mispred_cnt SHALL increment on each o_mispredict pulse and hold at 16'hFFFF.
REQ-025 Flush FSM states: IDLE, SWEEP. In IDLE, i_flush=1 SHALL transition to SWEEP with sweep index 0.
REQ-026 In SWEEP, one entry per cycle SHALL be written to WNT, index ascending; after index BHT_ENTRIES-1, the FSM SHALL return to IDLE (BHT_ENTRIES cycles in SWEEP).
REQ-027 o_busy SHALL be 1 exactly while in SWEEP.
REQ-028 In SWEEP, lookups SHALL still produce o_pred_valid, with o_pred_taken forced to 0.
REQ-029 In SWEEP, updates SHALL be ignored for the table, but o_mispredict and o_mispred_cnt SHALL still operate.
REQ-030 i_flush during SWEEP SHALL be ignored; the sweep is not restarted.

Reset
REQ-031 On i_rst assertion, immediately and asynchronously: all counters = WNT, FSM = IDLE, sweep index = 0, o_pred_valid = 0, o_pred_taken = 0, o_mispredict = 0, o_busy = 0, o_mispred_cnt = 0.
REQ-032 Reset mid-sweep SHALL abort the sweep; all entries become WNT regardless of sweep progress.

Structure
REQ-033 The t_bht_cnt enum (SNT/WNT/WT/ST) and BHT_ENTRIES default SHALL live in multicore_pkg; DATA_SIZE SHALL come from multicore_pkg.
REQ-034 The saturating next-state logic SHALL be a combinational sub-module sat_counter2 (inputs: count, taken; output: next count), instantiated once on the update path.
REQ-035 The table SHALL be flop-based (async reset required), not inferred RAM.

Verification
REQ-036 Reset, then lookup pc=0x40 -> next cycle o_pred_valid=1, o_pred_taken=0 (WNT).
REQ-037 Two taken updates at pc=0x40, then lookup 0x40 -> taken; three not-taken updates -> not taken; further not-taken updates hold at SNT.
REQ-038 Same cycle: update pc=0x80 taken (counter at WNT) and lookup 0x80 -> o_pred_taken=1 (bypass); lookup 0x84 the same cycle -> unaffected.
REQ-039 Update with taken=1, pred=0 -> o_mispredict=1 for one cycle and o_mispred_cnt=1; a matching update -> no pulse; 65540 mispredicts -> count holds at 0xFFFF.
REQ-040 Train entry 3 to ST, pulse i_flush -> o_busy high for 32 cycles; lookups return 0; entry 3 then reads WNT; an update during the sweep is ignored; i_flush during the sweep does not extend it.
REQ-041 Assert i_rst 10 cycles into the sweep -> o_busy=0 immediately and all entries are WNT after release.

Source files
------------

// File: rtl/multicore_pkg.sv
// Shared types and constants for the core: branch history counter encoding,
// flush FSM states and global widths.
package multicore_pkg;

  localparam int DATA_SIZE       = 32;
  localparam int BHT_ENTRIES_DEF = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } t_bht_cnt;

  typedef enum logic {
    FL_IDLE  = 1'b0,
    FL_SWEEP = 1'b1
  } t_flush_state;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating counter next-state: taken moves toward ST, not-taken
// toward SNT, both clamping at the ends.
module sat_counter2
  import multicore_pkg::*;
(
  input  t_bht_cnt count_i,
  input  logic     taken_i,
  output t_bht_cnt next_o
);

  always_comb begin
    next_o = count_i;
    if (taken_i) begin
      if (count_i != ST) next_o = t_bht_cnt'(count_i + 2'd1);
    end else begin
      if (count_i != SNT) next_o = t_bht_cnt'(count_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: flop-based table of 2-bit counters indexed by
// pc[IDX_W+1:2], one-cycle lookup with update bypass, and a sweeping flush.
module branch_predictor
  import multicore_pkg::*;
#(
  parameter int BHT_ENTRIES = BHT_ENTRIES_DEF,
  parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_lk_valid,
  input  logic [DATA_SIZE-1:0] i_lk_pc,
  output logic                 o_pred_valid,
  output logic                 o_pred_taken,
  input  logic                 i_upd_valid,
  input  logic [DATA_SIZE-1:0] i_upd_pc,
  input  logic                 i_upd_taken,
  input  logic                 i_upd_pred,
  output logic                 o_mispredict,
  input  logic                 i_flush,
  output logic                 o_busy,
  output logic [15:0]          o_mispred_cnt,
  output t_flush_state         o_dbg_state
);

  t_flush_state   state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
  t_bht_cnt       cnt_q [BHT_ENTRIES];
  t_bht_cnt       cnt_d [BHT_ENTRIES];
  logic           pred_valid_q, pred_valid_d;
  logic           pred_taken_q, pred_taken_d;
  logic           mispredict_q, mispredict_d;
  logic [15:0]    mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  t_bht_cnt       upd_next;
  logic           sweeping;

  assign lk_idx   = i_lk_pc[IDX_W+1:2];
  assign upd_idx  = i_upd_pc[IDX_W+1:2];
  assign sweeping = (state_q == FL_SWEEP);

  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_lk_pc[DATA_SIZE-1:IDX_W+2], i_lk_pc[1:0],
                            i_upd_pc[DATA_SIZE-1:IDX_W+2], i_upd_pc[1:0]};

  sat_counter2 u_sat (
    .count_i (cnt_q[upd_idx]),
    .taken_i (i_upd_taken),
    .next_o  (upd_next)
  );

  // Flush FSM: sweep index walks the table once, then returns to idle.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      FL_IDLE: begin
        if (i_flush) begin
          state_d     = FL_SWEEP;
          sweep_idx_d = '0;
        end
      end
      FL_SWEEP: begin
        sweep_idx_d = sweep_idx_q + 1'b1;
        if (sweep_idx_q == IDX_W'(BHT_ENTRIES - 1)) begin
          state_d     = FL_IDLE;
          sweep_idx_d = '0;
        end
      end
      default: state_d = FL_IDLE;
    endcase
  end

  // Table next state; the lookup reads cnt_d so a same-index update bypasses.
  always_comb begin
    cnt_d = cnt_q;
    if (sweeping) cnt_d[sweep_idx_q] = WNT;
    else if (i_upd_valid) cnt_d[upd_idx] = upd_next;
  end

  always_comb begin
    pred_valid_d  = i_lk_valid;
    pred_taken_d  = i_lk_valid && !sweeping && cnt_d[lk_idx][1];
    mispredict_d  = i_upd_valid && (i_upd_taken != i_upd_pred);
    mispred_cnt_d = mispred_cnt_q;
    if (mispredict_d && (mispred_cnt_q != 16'hFFFF)) mispred_cnt_d = mispred_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= FL_IDLE;
      sweep_idx_q   <= '0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      mispredict_q  <= 1'b0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) cnt_q[i] <= WNT;
    end else begin
      state_q       <= state_d;
      sweep_idx_q   <= sweep_idx_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      mispredict_q  <= mispredict_d;
      mispred_cnt_q <= mispred_cnt_d;
      for (int i = 0; i < BHT_ENTRIES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign o_pred_valid  = pred_valid_q;
  assign o_pred_taken  = pred_taken_q;
  assign o_mispredict  = mispredict_q;
  assign o_mispred_cnt = mispred_cnt_q;
  assign o_busy        = sweeping;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor against a table-of-ints
// reference model of the counter rules.
module tb_branch_predictor;
  import multicore_pkg::*;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lk_valid = 1'b0;
  logic [31:0] lk_pc = '0;
  logic        pred_valid, pred_taken;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        upd_pred = 1'b0;
  logic        mispredict;
  logic        flush = 1'b0;
  logic        busy;
  logic [15:0] mispred_cnt;
  t_flush_state dbg_state;

  int errors = 0;
  int checks = 0;

  // Reference model: counter values 0..3 per entry, misprediction count.
  int model [N];
  int mcnt;
  logic exp_pv, exp_pt, exp_mp;

  branch_predictor dut (
    .i_clk(clk), .i_rst(rst),
    .i_lk_valid(lk_valid), .i_lk_pc(lk_pc),
    .o_pred_valid(pred_valid), .o_pred_taken(pred_taken),
    .i_upd_valid(upd_valid), .i_upd_pc(upd_pc),
    .i_upd_taken(upd_taken), .i_upd_pred(upd_pred),
    .o_mispredict(mispredict), .i_flush(flush),
    .o_busy(busy), .o_mispred_cnt(mispred_cnt), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = 1;
    mcnt = 0;
  endtask

  // Drives one cycle of inputs at the falling edge, advances the model, and
  // returns at the next falling edge with exp_* holding the expected outputs.
  task automatic drive(input logic lv, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc,
                       input logic ut, input logic up,
                       input logic fl, input logic in_sweep);
    lk_valid = lv; lk_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_pred = up;
    flush = fl;
    if (uv && !in_sweep) begin
      if (ut) model[idx_of(upc)] = (model[idx_of(upc)] == 3) ? 3 : model[idx_of(upc)] + 1;
      else    model[idx_of(upc)] = (model[idx_of(upc)] == 0) ? 0 : model[idx_of(upc)] - 1;
    end
    exp_pv = lv;
    exp_pt = lv && !in_sweep && (model[idx_of(lpc)] >= 2);
    exp_mp = uv && (ut != up);
    if (exp_mp && mcnt < 65535) mcnt++;
    @(posedge clk);
    @(negedge clk);
    lk_valid = 1'b0; upd_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || mispredict !== 1'b0 ||
        busy !== 1'b0 || mispred_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: pv=%b pt=%b mp=%b busy=%b cnt=%0d expected all 0",
               pred_valid, pred_taken, mispredict, busy, mispred_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL first_lookup: pv=%b pt=%b expected pv=1 pt=0", pred_valid, pred_taken);
    end
    repeat (2) drive(0, 0, 1, 32'h40, 1, 1, 0, 0);
    drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_taken !== exp_pt || exp_pt !== 1'b1) begin
      errors++;
      $display("FAIL trained_taken: pt=%b expected %b", pred_taken, exp_pt);
    end
    repeat (5) drive(0, 0, 1, 32'h40, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h40, 1, 1, 0, 0);
    drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_taken !== exp_pt) begin
      errors++;
      $display("FAIL snt_saturate: pt=%b expected %b", pred_taken, exp_pt);
    end
    drive(1, 32'h40, 1, 32'h40, 1, 1, 0, 0);
    checks++;
    if (pred_taken !== exp_pt) begin
      errors++;
      $display("FAIL climb_after_snt: pt=%b expected %b", pred_taken, exp_pt);
    end
  endtask

  task automatic test_bypass();
    drive(1, 32'h80, 1, 32'h80, 1, 1, 0, 0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== exp_pt || exp_pt !== 1'b1) begin
      errors++;
      $display("FAIL bypass_same_idx: pv=%b pt=%b expected pv=1 pt=%b", pred_valid, pred_taken, exp_pt);
    end
    drive(1, 32'h84, 1, 32'h80, 1, 1, 0, 0);
    checks++;
    if (pred_taken !== exp_pt || exp_pt !== 1'b0) begin
      errors++;
      $display("FAIL independent_idx: pt=%b expected %b", pred_taken, exp_pt);
    end
  endtask

  task automatic test_mispredict();
    drive(0, 0, 1, 32'h100, 1, 0, 0, 0);
    checks++;
    if (mispredict !== 1'b1 || mispred_cnt !== 16'(mcnt)) begin
      errors++;
      $display("FAIL mispredict_pulse: mp=%b cnt=%0d expected mp=1 cnt=%0d", mispredict, mispred_cnt, mcnt);
    end
    drive(0, 0, 1, 32'h100, 1, 1, 0, 0);
    checks++;
    if (mispredict !== 1'b0 || mispred_cnt !== 16'(mcnt)) begin
      errors++;
      $display("FAIL match_no_pulse: mp=%b cnt=%0d expected mp=0 cnt=%0d", mispredict, mispred_cnt, mcnt);
    end
    upd_taken = 1'b1; upd_pred = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (mispredict !== 1'b0 || mispred_cnt !== 16'(mcnt)) begin
      errors++;
      $display("FAIL no_pulse_without_valid: mp=%b cnt=%0d expected mp=0 cnt=%0d", mispredict, mispred_cnt, mcnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] lpc, upc;
      lpc = $urandom;
      upc = ($urandom_range(0, 1) == 1) ? {$urandom_range(0, 255), 15'd0, lpc[8:2], 2'($urandom)} : $urandom;
      drive(1'($urandom), lpc, 1'($urandom), upc, 1'($urandom), 1'($urandom), 0, 0);
      checks++;
      if (pred_valid !== exp_pv || (exp_pv && pred_taken !== exp_pt) ||
          mispredict !== exp_mp || mispred_cnt !== 16'(mcnt)) begin
        errors++;
        $display("FAIL random_%0d: pv=%b pt=%b mp=%b cnt=%0d expected pv=%b pt=%b mp=%b cnt=%0d",
                 i, pred_valid, pred_taken, mispredict, mispred_cnt, exp_pv, exp_pt, exp_mp, mcnt);
      end
    end
  endtask

  task automatic test_flush();
    repeat (3) drive(0, 0, 1, 32'hC, 1, 1, 0, 0);
    drive(1, 32'hC, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL flush_pretrain: pt=%b expected 1", pred_taken);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < N; i++) model[i] = 1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_in_sweep_%0d: busy=%b expected 1", i, busy);
      end
      drive(1, 32'hC, (i >= 5 && i <= 7), 32'h10, 1, 0, (i == 10), 1);
      checks++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || mispredict !== exp_mp ||
          mispred_cnt !== 16'(mcnt)) begin
        errors++;
        $display("FAIL sweep_lookup_%0d: pv=%b pt=%b mp=%b cnt=%0d expected pv=1 pt=0 mp=%b cnt=%0d",
                 i, pred_valid, pred_taken, mispredict, mispred_cnt, exp_mp, mcnt);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_length: busy=%b expected 0 after %0d cycles", busy, N);
    end
    drive(1, 32'hC, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_taken !== exp_pt || exp_pt !== 1'b0) begin
      errors++;
      $display("FAIL entry3_flushed: pt=%b expected %b", pred_taken, exp_pt);
    end
    drive(1, 32'h10, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_taken !== exp_pt || exp_pt !== 1'b0) begin
      errors++;
      $display("FAIL sweep_update_ignored: pt=%b expected %b", pred_taken, exp_pt);
    end
  endtask

  task automatic test_reset_mid_sweep();
    repeat (2) drive(0, 0, 1, 32'h7C, 1, 1, 0, 0);
    repeat (2) drive(0, 0, 1, 32'h0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) drive(1, 32'h0, (i == 3), 32'h4, 1, 0, 0, 1);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || pred_valid !== 1'b0 || pred_taken !== 1'b0 ||
        mispredict !== 1'b0 || mispred_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_sweep: busy=%b pv=%b pt=%b mp=%b cnt=%0d expected all 0",
               busy, pred_valid, pred_taken, mispredict, mispred_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      drive(1, 32'(i * 4), 0, 0, 0, 0, 0, 0);
      drive(1, 32'(i * 4), 1, 32'(i * 4), 1, 1, 0, 0);
      checks++;
      if (pred_taken !== exp_pt || exp_pt !== 1'b1) begin
        errors++;
        $display("FAIL wnt_after_reset_%0d: pt=%b expected %b", i, pred_taken, exp_pt);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 65540; i++) drive(0, 0, 1, 32'h0, 1, 0, 0, 0);
    checks++;
    if (mispredict !== 1'b1 || mispred_cnt !== 16'hFFFF || mcnt != 65535) begin
      errors++;
      $display("FAIL cnt_saturate: mp=%b cnt=%h expected mp=1 cnt=ffff", mispredict, mispred_cnt);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (mispredict !== 1'b0 || mispred_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_hold: mp=%b cnt=%h expected mp=0 cnt=ffff", mispredict, mispred_cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_bypass();
    test_mispredict();
    test_random();
    test_flush();
    test_reset_mid_sweep();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
